// File: rtl/beat_timing_gen.sv
// Beat timing generator: produces the one-hot beat W, the T3 pulse and the
// beat-end pulse that drive the hardwired instruction controller.
// The QD button starts beat generation; STEP_MODE stops after every beat.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no beats generated; phase held at 0; waiting for a QD rising edge
// S_RUN  | phase counts 0..PHASES-1; W advances at the last phase of a beat

module beat_timing_gen #(
    parameter int PHASES = 4,
    parameter int CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             QD,
    input  logic             STEP_MODE,
    input  logic             SHORT,
    input  logic             LONG,
    input  logic             STOP,
    output logic [2:0]       W,
    output logic             T3,
    output logic             RUN,
    output logic             BEAT_END,
    output logic [CNT_W-1:0] BEAT_CNT
);

    localparam int PH_W = $clog2(PHASES);
    localparam logic [PH_W-1:0] PH_T3   = PH_W'(PHASES - 2);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);

    localparam logic [2:0] W1 = 3'b001;
    localparam logic [2:0] W2 = 3'b010;
    localparam logic [2:0] W3 = 3'b100;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [2:0]         w_q, w_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               qd_prev_q, qd_prev_d;

    logic               qd_rise;
    logic               boundary;
    logic [2:0]         w_next;

    // Register update; CLR abandons any beat in progress without advancing W.
    // qd_prev resets to 1 so a button held through reset does not start a run.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            w_q       <= W1;
            cnt_q     <= '0;
            qd_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            w_q       <= w_d;
            cnt_q     <= cnt_d;
            qd_prev_q <= qd_prev_d;
        end
    end

    // Beat sequencing: W1 -> W2 -> (W3) -> W1; any corrupted W returns to W1.
    always_comb begin
        w_next = W1;
        case (w_q)
            W1:      w_next = SHORT ? W1 : W2;
            W2:      w_next = LONG ? W3 : W1;
            W3:      w_next = W1;
            default: w_next = W1;
        endcase
    end

    // Next-state logic: start on a QD edge, advance phase, decide at beat boundary.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        w_d       = w_q;
        cnt_d     = cnt_q;
        qd_prev_d = QD;
        qd_rise   = QD & ~qd_prev_q;
        boundary  = (state_q == S_RUN) && (phase_q == PH_LAST);

        if (state_q == S_RUN) begin
            if (boundary) begin
                phase_d = '0;
                cnt_d   = cnt_q + CNT_W'(1);
                w_d     = w_next;
                if (STOP || STEP_MODE) begin
                    state_d = S_IDLE;
                end
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
        end else begin
            phase_d = '0;
            if (qd_rise) begin
                state_d = S_RUN;
            end
        end
    end

    // Decoded outputs; T3 and BEAT_END are only ever active while running.
    always_comb begin
        RUN      = (state_q == S_RUN);
        T3       = RUN && (phase_q == PH_T3);
        BEAT_END = RUN && (phase_q == PH_LAST);
        W        = w_q;
        BEAT_CNT = cnt_q;
    end

endmodule

// File: tb/tb_beat_timing_gen.sv
// Testbench for beat_timing_gen: directed vector table, hand-written corner
// sequences and randomized stimulus against a beat-level reference model.

module tb_beat_timing_gen;

    localparam int PH = 4;
    localparam int CW = 4;

    logic          clk;
    logic          clr, qd, step, sh, lg, stp;
    logic [2:0]    w;
    logic          t3, run, be;
    logic [CW-1:0] cnt;

    int n_total = 0;
    int n_pass  = 0;

    beat_timing_gen #(.PHASES(PH), .CNT_W(CW)) dut (
        .CLK(clk), .CLR(clr), .QD(qd), .STEP_MODE(step),
        .SHORT(sh), .LONG(lg), .STOP(stp),
        .W(w), .T3(t3), .RUN(run), .BEAT_END(be), .BEAT_CNT(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: current beat number (1..3), position within beat,
    // running flag, beat count and remembered button level.
    bit m_run   = 1'b0;
    int m_phase = 0;
    int m_beat  = 1;
    int m_cnt   = 0;
    bit m_qdp   = 1'b1;

    task automatic model_step();
        bit rise;
        if (clr) begin
            m_run = 0; m_phase = 0; m_beat = 1; m_cnt = 0; m_qdp = 1;
        end else begin
            rise  = qd && !m_qdp;
            m_qdp = qd;
            if (!m_run) begin
                if (rise) m_run = 1;
            end else if (m_phase == PH - 1) begin
                m_cnt   = (m_cnt + 1) % (1 << CW);
                m_phase = 0;
                if (m_beat == 1)      m_beat = sh ? 1 : 2;
                else if (m_beat == 2) m_beat = lg ? 3 : 1;
                else                  m_beat = 1;
                if (stp || step) m_run = 0;
            end else begin
                m_phase = m_phase + 1;
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic compare_model();
        chk("model_w",   int'(w),   1 << (m_beat - 1));
        chk("model_run", int'(run), int'(m_run));
        chk("model_t3",  int'(t3),  int'(m_run && m_phase == PH - 2));
        chk("model_be",  int'(be),  int'(m_run && m_phase == PH - 1));
        chk("model_cnt", int'(cnt), m_cnt);
    endtask

    task automatic tick(input bit cmp);
        @(posedge clk);
        model_step();
        #1;
        if (cmp) compare_model();
    endtask

    task automatic do_reset();
        clr = 1; qd = 1; step = 0; sh = 0; lg = 0; stp = 0;
        tick(1);
        tick(1);
        clr = 0;
    endtask

    task automatic press();
        qd = 0; tick(1);
        qd = 1; tick(1);
    endtask

    typedef struct {
        bit clr, qd, step, sh, lg, stp;
        int w;
        bit run, t3, be;
        int cnt;
    } vec_t;

    function automatic vec_t mk(bit c, bit q, bit s, bit h, bit l, bit p,
                                int ew, bit er, bit et, bit eb, int ec);
        vec_t v;
        v.clr = c; v.qd = q; v.step = s; v.sh = h; v.lg = l; v.stp = p;
        v.w = ew; v.run = er; v.t3 = et; v.be = eb; v.cnt = ec;
        return v;
    endfunction

    vec_t tv[24];

    initial begin
        int t3_cnt;
        int be_cnt;
        int beat_w[3];

        clr = 1; qd = 1; step = 0; sh = 0; lg = 0; stp = 0;

        // Reset with QD held, release, restart, W1->W2->W3(LONG)->W1, STOP at W1.
        tv[0]  = mk(1,1,0,0,0,0, 1,0,0,0,0);
        tv[1]  = mk(1,1,0,0,0,0, 1,0,0,0,0);
        tv[2]  = mk(0,1,0,0,0,0, 1,0,0,0,0);
        tv[3]  = mk(0,1,0,0,0,0, 1,0,0,0,0);
        tv[4]  = mk(0,0,0,0,0,0, 1,0,0,0,0);
        tv[5]  = mk(0,1,0,0,0,0, 1,1,0,0,0);
        tv[6]  = mk(0,1,0,0,0,0, 1,1,0,0,0);
        tv[7]  = mk(0,1,0,0,0,0, 1,1,1,0,0);
        tv[8]  = mk(0,1,0,0,0,0, 1,1,0,1,0);
        tv[9]  = mk(0,1,0,0,0,0, 2,1,0,0,1);
        tv[10] = mk(0,1,0,0,0,0, 2,1,0,0,1);
        tv[11] = mk(0,1,0,0,0,0, 2,1,1,0,1);
        tv[12] = mk(0,1,0,0,0,0, 2,1,0,1,1);
        tv[13] = mk(0,1,0,1,1,0, 4,1,0,0,2);
        tv[14] = mk(0,1,0,0,0,0, 4,1,0,0,2);
        tv[15] = mk(0,1,0,0,0,0, 4,1,1,0,2);
        tv[16] = mk(0,1,0,0,0,0, 4,1,0,1,2);
        tv[17] = mk(0,1,0,1,1,0, 1,1,0,0,3);
        tv[18] = mk(0,1,0,0,0,0, 1,1,0,0,3);
        tv[19] = mk(0,1,0,0,0,0, 1,1,1,0,3);
        tv[20] = mk(0,1,0,0,0,0, 1,1,0,1,3);
        tv[21] = mk(0,1,0,0,0,1, 2,0,0,0,4);
        tv[22] = mk(0,0,0,0,0,0, 2,0,0,0,4);
        tv[23] = mk(0,1,0,0,0,0, 2,1,0,0,4);

        for (int i = 0; i < 24; i++) begin
            clr = tv[i].clr; qd = tv[i].qd; step = tv[i].step;
            sh = tv[i].sh; lg = tv[i].lg; stp = tv[i].stp;
            tick(0);
            chk($sformatf("vec%0d_w", i),   int'(w),   tv[i].w);
            chk($sformatf("vec%0d_run", i), int'(run), int'(tv[i].run));
            chk($sformatf("vec%0d_t3", i),  int'(t3),  int'(tv[i].t3));
            chk($sformatf("vec%0d_be", i),  int'(be),  int'(tv[i].be));
            chk($sformatf("vec%0d_cnt", i), int'(cnt), tv[i].cnt);
        end
        sh = 0; lg = 0; stp = 0;

        // STOP at the W1 boundary: idle at W2 with T3 silent, then resume at W2.
        do_reset();
        press();
        tick(1); tick(1); tick(1);
        stp = 1;
        tick(1);
        stp = 0;
        chk("stop_run", int'(run), 0);
        chk("stop_w", int'(w), 2);
        t3_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (t3) t3_cnt++;
        end
        chk("stop_t3_silent", t3_cnt, 0);
        press();
        chk("resume_run", int'(run), 1);
        chk("resume_w", int'(w), 2);

        // Step mode: three presses give three beats; a mid-beat press adds nothing.
        do_reset();
        step = 1;
        be_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            beat_w[k] = 0;
            press();
            for (int j = 0; j < 4; j++) begin
                if (k == 1 && j == 1) qd = 0;
                if (k == 1 && j == 2) qd = 1;
                tick(1);
                if (t3) beat_w[k] = int'(w);
                if (be) be_cnt++;
            end
        end
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (be) be_cnt++;
        end
        chk("step_beats", be_cnt, 3);
        chk("step_cnt", int'(cnt), 3);
        chk("step_run", int'(run), 0);
        chk("step_w0", beat_w[0], 1);
        chk("step_w1", beat_w[1], 2);
        chk("step_w2", beat_w[2], 1);
        step = 0;

        // SHORT and LONG together in W1: SHORT wins, W stays W1.
        do_reset();
        press();
        sh = 1; lg = 1;
        for (int i = 0; i < 4; i++) tick(1);
        sh = 0; lg = 0;
        chk("short_long_w", int'(w), 1);
        chk("short_long_cnt", int'(cnt), 1);

        // Counter wrap after 16 beats, then CLR in phase 2 of W2.
        do_reset();
        press();
        for (int i = 0; i < 64; i++) tick(1);
        chk("wrap_cnt", int'(cnt), 0);
        chk("wrap_w", int'(w), 1);
        for (int i = 0; i < 6; i++) tick(1);
        chk("pre_clr_t3", int'(t3), 1);
        chk("pre_clr_w", int'(w), 2);
        clr = 1;
        tick(1);
        clr = 0;
        chk("clr_w", int'(w), 1);
        chk("clr_run", int'(run), 0);
        chk("clr_t3", int'(t3), 0);

        // Randomized stimulus against the reference model.
        for (int i = 0; i < 800; i++) begin
            clr  = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 2) == 0) qd = ~qd;
            if ($urandom_range(0, 39) == 0) step = ~step;
            sh  = $urandom_range(0, 1);
            lg  = $urandom_range(0, 1);
            stp = ($urandom_range(0, 5) == 0);
            tick(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
